mem_access_stage: RTL and testbench
===================================

Name: mem_access_stage

Overview:
- Downstream neighbour of the execute stage: EX/MEM pipeline register plus memory-access stage, ending in a registered MEM/WB output.
- Captures the execute stage outputs and drives a valid/ack data-memory port with byte enables.
- Aligns and sign-extends load data, stalls the pipe while memory is busy, and supplies the EX/MEM forwarding sources.

Parameters:
- WAIT_MAX, 255: max cycles dmem_req may stay high without dmem_ack before abort; legal range 1..65535.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset
- ex_valid_in  in  1  EX slot holds a real instruction
- alu_result_in  in  32  ALU result / effective address
- rs2_data_in  in  32  forwarded store data
- rd_in  in  5  destination register
- funct3_in  in  3  load/store width code
- RegWrite_in, MemRead_in, MemWrite_in, MemToReg_in  in  1 each  control bits
- mem_stall  out  1  hold upstream stages and the EX/MEM register
- ex_mem_alu_result  out  32  forwarding source (M-slot ALU value)
- ex_mem_rd  out  5  M-slot rd
- ex_mem_RegWrite  out  1  m_valid & m_RegWrite
- dmem_req  out  1  access request
- dmem_we  out  1  1 = store
- dmem_addr  out  32  word address, bits[1:0]=0
- dmem_be  out  4  byte enables
- dmem_wdata  out  32  lane-replicated store data
- dmem_ack  in  1  access complete; rdata valid this cycle
- dmem_rdata  in  32  read word
- wb_valid, wb_RegWrite, wb_MemToReg  out  1 each  MEM/WB control
- wb_rd  out  5  MEM/WB rd
- wb_alu_result  out  32  MEM/WB ALU value
- wb_load_data  out  32  aligned/extended load value
- dmem_timeout  out  1  sticky abort flag
- misalign_err  out  1  see Optional Feature

Interface (already decided):
- One clock; reset is asynchronous and active-low.
- Clock port is clk; reset port is rst_n.

Behaviour:
- Reset: all M-slot and WB registers, mem_stall, dmem_timeout, misalign_err and the wait counter are 0; FSM enters IDLE.
- M slot: captures all EX inputs on posedge when mem_stall=0; holds while mem_stall=1.
- mem_op = m_valid & (m_MemRead | m_MemWrite).
- dmem_req = mem_op & (state != DONE).
- dmem_we = m_MemWrite; dmem_addr = {m_alu[31:2], 2'b00}. Request fields are stable from registers while req=1.
- FSM:
  - IDLE -> WAIT when mem_op & !dmem_ack.
  - WAIT -> IDLE on dmem_ack.
  - WAIT -> DONE on abort (counter reaches WAIT_MAX); DONE -> IDLE next cycle.
  - mem_op & dmem_ack in IDLE completes in zero wait cycles.
- Stall and abort:
  - mem_stall = dmem_req & !dmem_ack & !abort.
  - On abort, dmem_timeout sets (sticky until reset) and wb_RegWrite for that instruction is forced 0.
- Wait counter: clears when not in WAIT; increments per WAIT cycle; saturates at WAIT_MAX.
- Store lanes (off = m_alu[1:0]):
  - SB: be = 4'b0001 << off; wdata = {4{rs2[7:0]}}.
  - SH: be = off[1] ? 4'b1100 : 4'b0011; wdata = {2{rs2[15:0]}}.
  - SW: be = 4'b1111; wdata = rs2.
  - be = 0 for loads.
- Load alignment, by funct3:
  - 000 LB: sign-extended byte at off.
  - 001 LH: sign-extended half at off[1].
  - 010 LW: full word.
  - 100 LBU / 101 LHU: zero-extended byte / half.
  - Other codes: full word.
- WB registers (posedge):
  - If mem_stall=1: wb_valid <= 0 and wb_RegWrite <= 0 (bubble).
  - Else: wb_valid <= m_valid; wb_RegWrite <= m_valid & m_RegWrite & !abort; rd, MemToReg, alu copied.
  - wb_load_data loads the aligned rdata only when a load completes; otherwise it holds.
- Edge cases:
  - Non-memory instructions pass M to WB in 1 cycle.
  - Back-to-back memory ops are each stalled independently.
  - Reset asserted mid-WAIT abandons the request immediately (req=0 asynchronously).

Optional Feature:
- Macro: MISALIGN_TRAP_EN.
- Defined:
  - LH/LHU/SH with off[0]=1, or LW/SW with off != 0, never raises dmem_req and never stalls.
  - WB registers misalign_err=1 for one cycle with wb_RegWrite=0.
- Undefined:
  - misalign_err is tied 0.
  - Halfword accesses use off[1]; word accesses ignore off.

Test Plan:
- Reset mid-WAIT (rst_n low with req pending) -> dmem_req, mem_stall and all wb_* are 0 immediately; FSM in IDLE after release.
- ADD result 0x0000_0042, rd=5, RegWrite=1 -> ex_mem_alu_result=0x42 next cycle; wb_RegWrite=1, wb_rd=5, wb_alu_result=0x42 one cycle later; mem_stall never asserted.
- LB addr 0x1003, ack after 3 cycles, rdata 0x80FF_0000 -> mem_stall high 3 cycles, dmem_addr=0x1000; wb_load_data=0xFFFF_FF80.
- SH addr 0x2002, rs2 0x1234_ABCD, ack same cycle -> dmem_be=4'b1100, dmem_wdata=0xABCD_ABCD, dmem_we=1, no stall.
- LW with WAIT_MAX=4 and no ack -> abort after 4 WAIT cycles; dmem_timeout=1 sticky; wb_RegWrite=0; next instruction proceeds.
- MISALIGN_TRAP_EN defined, LW addr 0x3001 -> no dmem_req; misalign_err=1 for one cycle; wb_RegWrite=0.

Source files
------------

// File: rtl/mem_access_stage.sv
// EX/MEM pipeline register, data-memory access FSM and registered MEM/WB output.
// Optional feature: define MISALIGN_TRAP_EN to trap misaligned half/word accesses.
module mem_access_stage #(
    parameter int unsigned WAIT_MAX = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex_valid_in,
    input  logic [31:0] alu_result_in,
    input  logic [31:0] rs2_data_in,
    input  logic [4:0]  rd_in,
    input  logic [2:0]  funct3_in,
    input  logic        RegWrite_in,
    input  logic        MemRead_in,
    input  logic        MemWrite_in,
    input  logic        MemToReg_in,
    output logic        mem_stall,
    output logic [31:0] ex_mem_alu_result,
    output logic [4:0]  ex_mem_rd,
    output logic        ex_mem_RegWrite,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        wb_valid,
    output logic        wb_RegWrite,
    output logic        wb_MemToReg,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_alu_result,
    output logic [31:0] wb_load_data,
    output logic        dmem_timeout,
    output logic        misalign_err
);

    localparam logic [15:0] WaitMax = 16'(WAIT_MAX);

    typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

    state_e      state_q, state_d;
    logic [15:0] wait_cnt_q, wait_cnt_d;

    logic        m_valid;
    logic [31:0] m_alu;
    logic [31:0] m_rs2;
    logic [4:0]  m_rd;
    logic [2:0]  m_funct3;
    logic        m_RegWrite, m_MemRead, m_MemWrite, m_MemToReg;

    logic [1:0]  off;
    logic        misaligned;
    logic        mem_op;
    logic        abort;
    logic        load_done;
    logic [31:0] load_aligned;
    logic [7:0]  load_byte;
    logic [15:0] load_half;

    // EX/MEM register: frozen while the memory access is outstanding
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid    <= 1'b0;
            m_alu      <= '0;
            m_rs2      <= '0;
            m_rd       <= '0;
            m_funct3   <= '0;
            m_RegWrite <= 1'b0;
            m_MemRead  <= 1'b0;
            m_MemWrite <= 1'b0;
            m_MemToReg <= 1'b0;
        end else if (!mem_stall) begin
            m_valid    <= ex_valid_in;
            m_alu      <= alu_result_in;
            m_rs2      <= rs2_data_in;
            m_rd       <= rd_in;
            m_funct3   <= funct3_in;
            m_RegWrite <= RegWrite_in;
            m_MemRead  <= MemRead_in;
            m_MemWrite <= MemWrite_in;
            m_MemToReg <= MemToReg_in;
        end
    end

    assign off = m_alu[1:0];

`ifdef MISALIGN_TRAP_EN
    assign misaligned = m_valid & (m_MemRead | m_MemWrite) &
                        ((((m_funct3 == 3'b001) | (m_funct3 == 3'b101)) & off[0]) |
                         ((m_funct3 == 3'b010) & (off != 2'b00)));
`else
    assign misaligned = 1'b0;
`endif

    assign mem_op    = m_valid & (m_MemRead | m_MemWrite) & ~misaligned;
    assign dmem_req  = mem_op & (state_q != StDone);
    assign dmem_we   = m_MemWrite;
    assign dmem_addr = {m_alu[31:2], 2'b00};
    assign abort     = (state_q == StWait) & ~dmem_ack & (wait_cnt_q == WaitMax);
    assign mem_stall = dmem_req & ~dmem_ack & ~abort;
    assign load_done = dmem_req & dmem_ack & m_MemRead;

    assign ex_mem_alu_result = m_alu;
    assign ex_mem_rd         = m_rd;
    assign ex_mem_RegWrite   = m_valid & m_RegWrite;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (mem_op && !dmem_ack) state_d = StWait;
            StWait: begin
                if (dmem_ack)   state_d = StIdle;
                else if (abort) state_d = StDone;
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        wait_cnt_d = '0;
        if (state_q == StWait) begin
            wait_cnt_d = (wait_cnt_q == WaitMax) ? wait_cnt_q : wait_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // Store lanes: narrow data is replicated so any byte lane sees it
    always_comb begin
        dmem_be    = 4'b0000;
        dmem_wdata = m_rs2;
        case (m_funct3[1:0])
            2'b00: begin
                dmem_be    = 4'b0001 << off;
                dmem_wdata = {4{m_rs2[7:0]}};
            end
            2'b01: begin
                dmem_be    = off[1] ? 4'b1100 : 4'b0011;
                dmem_wdata = {2{m_rs2[15:0]}};
            end
            default: dmem_be = 4'b1111;
        endcase
        if (!m_MemWrite) dmem_be = 4'b0000;
    end

    always_comb begin
        load_half = off[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        case (off)
            2'b00:   load_byte = dmem_rdata[7:0];
            2'b01:   load_byte = dmem_rdata[15:8];
            2'b10:   load_byte = dmem_rdata[23:16];
            default: load_byte = dmem_rdata[31:24];
        endcase
        case (m_funct3)
            3'b000:  load_aligned = {{24{load_byte[7]}}, load_byte};
            3'b001:  load_aligned = {{16{load_half[15]}}, load_half};
            3'b100:  load_aligned = {24'd0, load_byte};
            3'b101:  load_aligned = {16'd0, load_half};
            default: load_aligned = dmem_rdata;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_valid      <= 1'b0;
            wb_RegWrite   <= 1'b0;
            wb_MemToReg   <= 1'b0;
            wb_rd         <= '0;
            wb_alu_result <= '0;
            wb_load_data  <= '0;
            dmem_timeout  <= 1'b0;
        end else begin
            if (mem_stall) begin
                wb_valid    <= 1'b0;
                wb_RegWrite <= 1'b0;
            end else begin
                wb_valid      <= m_valid;
                wb_RegWrite   <= m_valid & m_RegWrite & ~abort & ~misaligned;
                wb_MemToReg   <= m_MemToReg;
                wb_rd         <= m_rd;
                wb_alu_result <= m_alu;
            end
            if (load_done) wb_load_data <= load_aligned;
            if (abort)     dmem_timeout <= 1'b1;
        end
    end

`ifdef MISALIGN_TRAP_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)         misalign_err <= 1'b0;
        else if (mem_stall) misalign_err <= 1'b0;
        else                misalign_err <= misaligned;
    end
`else
    assign misalign_err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed self-checking bench for mem_access_stage (WAIT_MAX overridden to 4).
module tb_mem_access_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex_valid_in;
    logic [31:0] alu_result_in, rs2_data_in;
    logic [4:0]  rd_in;
    logic [2:0]  funct3_in;
    logic        RegWrite_in, MemRead_in, MemWrite_in, MemToReg_in;
    logic        mem_stall;
    logic [31:0] ex_mem_alu_result;
    logic [4:0]  ex_mem_rd;
    logic        ex_mem_RegWrite;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic        wb_valid, wb_RegWrite, wb_MemToReg;
    logic [4:0]  wb_rd;
    logic [31:0] wb_alu_result, wb_load_data;
    logic        dmem_timeout, misalign_err;

    int checks = 0;
    int errors = 0;

    mem_access_stage #(.WAIT_MAX(4)) dut (
        .clk(clk), .rst_n(rst_n), .ex_valid_in(ex_valid_in), .alu_result_in(alu_result_in),
        .rs2_data_in(rs2_data_in), .rd_in(rd_in), .funct3_in(funct3_in),
        .RegWrite_in(RegWrite_in), .MemRead_in(MemRead_in), .MemWrite_in(MemWrite_in),
        .MemToReg_in(MemToReg_in), .mem_stall(mem_stall), .ex_mem_alu_result(ex_mem_alu_result),
        .ex_mem_rd(ex_mem_rd), .ex_mem_RegWrite(ex_mem_RegWrite), .dmem_req(dmem_req),
        .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .wb_valid(wb_valid),
        .wb_RegWrite(wb_RegWrite), .wb_MemToReg(wb_MemToReg), .wb_rd(wb_rd),
        .wb_alu_result(wb_alu_result), .wb_load_data(wb_load_data),
        .dmem_timeout(dmem_timeout), .misalign_err(misalign_err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ex(input logic [31:0] alu, input logic [31:0] rs2, input logic [4:0] rd,
                          input logic [2:0] f3, input logic rw, input logic mr,
                          input logic mw, input logic m2r);
        ex_valid_in   = 1'b1;
        alu_result_in = alu;
        rs2_data_in   = rs2;
        rd_in         = rd;
        funct3_in     = f3;
        RegWrite_in   = rw;
        MemRead_in    = mr;
        MemWrite_in   = mw;
        MemToReg_in   = m2r;
    endtask

    task automatic clear_ex();
        ex_valid_in   = 1'b0;
        alu_result_in = '0;
        rs2_data_in   = '0;
        rd_in         = '0;
        funct3_in     = '0;
        RegWrite_in   = 1'b0;
        MemRead_in    = 1'b0;
        MemWrite_in   = 1'b0;
        MemToReg_in   = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        clear_ex();
        dmem_ack = 1'b0;
        dmem_rdata = '0;
        #2;
        checks++; if (dmem_req !== 1'b0) begin errors++; $display("FAIL rst_req got %b want 0", dmem_req); end
        checks++; if (mem_stall !== 1'b0) begin errors++; $display("FAIL rst_stall got %b want 0", mem_stall); end
        checks++; if (wb_valid !== 1'b0 || wb_RegWrite !== 1'b0) begin errors++; $display("FAIL rst_wb got %b%b want 00", wb_valid, wb_RegWrite); end
        checks++; if (wb_load_data !== 32'h0) begin errors++; $display("FAIL rst_ld got %h want 0", wb_load_data); end
        checks++; if (dmem_timeout !== 1'b0 || misalign_err !== 1'b0) begin errors++; $display("FAIL rst_flags got %b%b want 00", dmem_timeout, misalign_err); end
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_alu();
        set_ex(32'h0000_0042, 32'h0, 5'd5, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0);
        step();
        clear_ex();
        checks++; if (ex_mem_alu_result !== 32'h42) begin errors++; $display("FAIL alu_fwd got %h want 42", ex_mem_alu_result); end
        checks++; if (ex_mem_rd !== 5'd5 || ex_mem_RegWrite !== 1'b1) begin errors++; $display("FAIL alu_fwd_rd got %0d/%b want 5/1", ex_mem_rd, ex_mem_RegWrite); end
        checks++; if (mem_stall !== 1'b0 || dmem_req !== 1'b0) begin errors++; $display("FAIL alu_nostall got %b%b want 00", mem_stall, dmem_req); end
        step();
        checks++; if (wb_RegWrite !== 1'b1 || wb_rd !== 5'd5 || wb_alu_result !== 32'h42) begin
            errors++; $display("FAIL alu_wb got %b/%0d/%h want 1/5/42", wb_RegWrite, wb_rd, wb_alu_result); end
    endtask

    task automatic test_load_lb();
        set_ex(32'h0000_1003, 32'h0, 5'd7, 3'b000, 1'b1, 1'b1, 1'b0, 1'b1);
        step();
        clear_ex();
        for (int i = 0; i < 3; i++) begin
            checks++; if (mem_stall !== 1'b1 || dmem_req !== 1'b1 || dmem_we !== 1'b0) begin
                errors++; $display("FAIL lb_stall%0d got %b%b%b want 110", i, mem_stall, dmem_req, dmem_we); end
            checks++; if (dmem_addr !== 32'h1000 || dmem_be !== 4'b0000) begin
                errors++; $display("FAIL lb_addr%0d got %h/%b want 1000/0000", i, dmem_addr, dmem_be); end
            step();
        end
        dmem_ack = 1'b1;
        dmem_rdata = 32'h80FF_0000;
        #1;
        checks++; if (mem_stall !== 1'b0) begin errors++; $display("FAIL lb_ack_stall got %b want 0", mem_stall); end
        step();
        dmem_ack = 1'b0;
        checks++; if (wb_load_data !== 32'hFFFF_FF80) begin errors++; $display("FAIL lb_data got %h want ffffff80", wb_load_data); end
        checks++; if (wb_RegWrite !== 1'b1 || wb_MemToReg !== 1'b1 || wb_rd !== 5'd7) begin
            errors++; $display("FAIL lb_wb got %b%b/%0d want 11/7", wb_RegWrite, wb_MemToReg, wb_rd); end
    endtask

    task automatic test_store();
        set_ex(32'h0000_2002, 32'h1234_ABCD, 5'd0, 3'b001, 1'b0, 1'b0, 1'b1, 1'b0);
        step();
        clear_ex();
        dmem_ack = 1'b1;
        #1;
        checks++; if (dmem_be !== 4'b1100 || dmem_wdata !== 32'hABCD_ABCD) begin
            errors++; $display("FAIL sh_lane got %b/%h want 1100/abcdabcd", dmem_be, dmem_wdata); end
        checks++; if (dmem_we !== 1'b1 || dmem_req !== 1'b1 || mem_stall !== 1'b0 || dmem_addr !== 32'h2000) begin
            errors++; $display("FAIL sh_req got %b%b%b/%h want 110/2000", dmem_we, dmem_req, mem_stall, dmem_addr); end
        step();
        dmem_ack = 1'b0;
        set_ex(32'h0000_2001, 32'h0000_005A, 5'd0, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0);
        step();
        clear_ex();
        dmem_ack = 1'b1;
        #1;
        checks++; if (dmem_be !== 4'b0010 || dmem_wdata !== 32'h5A5A_5A5A) begin
            errors++; $display("FAIL sb_lane got %b/%h want 0010/5a5a5a5a", dmem_be, dmem_wdata); end
        step();
        dmem_ack = 1'b0;
    endtask

    task automatic test_back_to_back();
        set_ex(32'h0000_4002, 32'h0, 5'd10, 3'b101, 1'b1, 1'b1, 1'b0, 1'b1);
        step();
        set_ex(32'h0000_5000, 32'hDEAD_BEEF, 5'd0, 3'b010, 1'b0, 1'b0, 1'b1, 1'b0);
        #1;
        checks++; if (mem_stall !== 1'b1 || dmem_addr !== 32'h4000) begin
            errors++; $display("FAIL b2b_lhu got %b/%h want 1/4000", mem_stall, dmem_addr); end
        step();
        dmem_ack = 1'b1;
        dmem_rdata = 32'h8001_7F00;
        #1;
        step();
        clear_ex();
        dmem_ack = 1'b0;
        #1;
        checks++; if (wb_load_data !== 32'h0000_8001 || wb_rd !== 5'd10 || wb_RegWrite !== 1'b1) begin
            errors++; $display("FAIL b2b_lhu_wb got %h/%0d/%b want 00008001/10/1", wb_load_data, wb_rd, wb_RegWrite); end
        checks++; if (dmem_we !== 1'b1 || dmem_be !== 4'b1111 || dmem_wdata !== 32'hDEAD_BEEF || dmem_addr !== 32'h5000) begin
            errors++; $display("FAIL b2b_sw got %b/%b/%h/%h want 1/1111/deadbeef/5000", dmem_we, dmem_be, dmem_wdata, dmem_addr); end
        checks++; if (mem_stall !== 1'b1) begin errors++; $display("FAIL b2b_sw_stall got %b want 1", mem_stall); end
        step();
        dmem_ack = 1'b1;
        #1;
        step();
        dmem_ack = 1'b0;
        checks++; if (wb_valid !== 1'b1 || wb_RegWrite !== 1'b0 || wb_load_data !== 32'h0000_8001) begin
            errors++; $display("FAIL b2b_sw_wb got %b%b/%h want 10/00008001", wb_valid, wb_RegWrite, wb_load_data); end
    endtask

    task automatic test_timeout();
        int n;
        set_ex(32'h0000_6000, 32'h0, 5'd9, 3'b010, 1'b1, 1'b1, 1'b0, 1'b1);
        step();
        clear_ex();
        n = 0;
        while (mem_stall && n < 20) begin
            n++;
            step();
        end
        // One IDLE request cycle plus four WAIT cycles before the counter hits WAIT_MAX
        checks++; if (n != 5) begin errors++; $display("FAIL to_stall_cycles got %0d want 5", n); end
        checks++; if (dmem_req !== 1'b1 || dmem_timeout !== 1'b0) begin
            errors++; $display("FAIL to_abort_cycle got %b%b want 10", dmem_req, dmem_timeout); end
        set_ex(32'h0000_0077, 32'h0, 5'd12, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0);
        step();
        clear_ex();
        checks++; if (dmem_timeout !== 1'b1 || wb_valid !== 1'b1 || wb_RegWrite !== 1'b0) begin
            errors++; $display("FAIL to_wb got %b%b%b want 110", dmem_timeout, wb_valid, wb_RegWrite); end
        step();
        checks++; if (wb_RegWrite !== 1'b1 || wb_rd !== 5'd12 || wb_alu_result !== 32'h77 || dmem_timeout !== 1'b1) begin
            errors++; $display("FAIL to_next got %b/%0d/%h/%b want 1/12/77/1", wb_RegWrite, wb_rd, wb_alu_result, dmem_timeout); end
    endtask

    task automatic test_reset_mid_wait();
        set_ex(32'h0000_7000, 32'h0, 5'd4, 3'b010, 1'b1, 1'b1, 1'b0, 1'b1);
        step();
        clear_ex();
        step();
        step();
        checks++; if (dmem_req !== 1'b1) begin errors++; $display("FAIL rmw_pending got %b want 1", dmem_req); end
        rst_n = 1'b0;
        #1;
        checks++; if (dmem_req !== 1'b0 || mem_stall !== 1'b0) begin
            errors++; $display("FAIL rmw_req got %b%b want 00", dmem_req, mem_stall); end
        checks++; if (wb_valid !== 1'b0 || wb_RegWrite !== 1'b0 || wb_rd !== 5'd0 || wb_alu_result !== 32'h0 || dmem_timeout !== 1'b0) begin
            errors++; $display("FAIL rmw_wb got %b%b/%0d/%h/%b want 00/0/0/0", wb_valid, wb_RegWrite, wb_rd, wb_alu_result, dmem_timeout); end
        step();
        rst_n = 1'b1;
        set_ex(32'h0000_7001, 32'h0, 5'd6, 3'b000, 1'b1, 1'b1, 1'b0, 1'b1);
        step();
        clear_ex();
        dmem_ack = 1'b1;
        dmem_rdata = 32'h0000_AB00;
        #1;
        checks++; if (mem_stall !== 1'b0 || dmem_req !== 1'b1) begin
            errors++; $display("FAIL rmw_idle got %b%b want 01", mem_stall, dmem_req); end
        step();
        dmem_ack = 1'b0;
        checks++; if (wb_load_data !== 32'hFFFF_FFAB) begin errors++; $display("FAIL rmw_ld got %h want ffffffab", wb_load_data); end
    endtask

    task automatic test_misalign();
        set_ex(32'h0000_3001, 32'h0, 5'd3, 3'b010, 1'b1, 1'b1, 1'b0, 1'b1);
        step();
        clear_ex();
`ifdef MISALIGN_TRAP_EN
        checks++; if (dmem_req !== 1'b0 || mem_stall !== 1'b0) begin
            errors++; $display("FAIL mis_req got %b%b want 00", dmem_req, mem_stall); end
        step();
        checks++; if (misalign_err !== 1'b1 || wb_RegWrite !== 1'b0 || wb_valid !== 1'b1) begin
            errors++; $display("FAIL mis_wb got %b%b%b want 101", misalign_err, wb_RegWrite, wb_valid); end
        step();
        checks++; if (misalign_err !== 1'b0) begin errors++; $display("FAIL mis_pulse got %b want 0", misalign_err); end
`else
        checks++; if (dmem_req !== 1'b1 || dmem_addr !== 32'h3000) begin
            errors++; $display("FAIL mis_off_req got %b/%h want 1/3000", dmem_req, dmem_addr); end
        dmem_ack = 1'b1;
        dmem_rdata = 32'h1122_3344;
        #1;
        step();
        dmem_ack = 1'b0;
        checks++; if (misalign_err !== 1'b0 || wb_RegWrite !== 1'b1 || wb_load_data !== 32'h1122_3344) begin
            errors++; $display("FAIL mis_off_wb got %b%b/%h want 01/11223344", misalign_err, wb_RegWrite, wb_load_data); end
`endif
    endtask

    initial begin
        test_reset();
        test_alu();
        test_load_lb();
        test_store();
        test_back_to_back();
        test_timeout();
        test_reset_mid_wait();
        test_misalign();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
